// File: rtl/video_scanout.sv
// video_scanout: programmable video timing, banked VRAM fetch and pixel expansion.
// Fixed three-stage pipe from the S0 counters to the aligned rgb/sync outputs.
module video_scanout #(
  parameter int H_PIXELS      = 800,
  parameter int H_FRONT_PORCH = 48,
  parameter int H_SYNC        = 32,
  parameter int H_BACK_PORCH  = 80,
  parameter int V_PIXELS      = 600,
  parameter int V_FRONT_PORCH = 3,
  parameter int V_SYNC        = 4,
  parameter int V_BACK_PORCH  = 11,
  parameter int HSYNC_POL     = 1,
  parameter int VSYNC_POL     = 0,
  parameter int SCALE         = 1,
  parameter int NUM_BANKS     = 2,
  parameter int ADDR_W        = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          page_sel,
  input  logic                          mode,
  output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  input  logic [NUM_BANKS*8-1:0]        bank_q,
  output logic                          page_active,
  output logic                          frame_start,
  output logic                          vblank,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          draw_area,
  output logic [7:0]                    red,
  output logic [7:0]                    green,
  output logic [7:0]                    blue
);

  localparam int H_TOTAL = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int SRC_W = H_PIXELS / SCALE;
  localparam int SRC_PIX = SRC_W * (V_PIXELS / SCALE);
  localparam int PAGE_WORDS = (SRC_PIX + NUM_BANKS - 1) / NUM_BANKS;
  localparam int IDX_W = $clog2(SRC_PIX + 1);
  localparam int AF_W = (IDX_W + 1 > ADDR_W) ? IDX_W + 1 : ADDR_W;
  localparam int BK_SH = $clog2(NUM_BANKS);
  localparam int BK_W = (BK_SH > 0) ? BK_SH : 1;

  localparam logic HS_ON = 1'(HSYNC_POL);
  localparam logic VS_ON = 1'(VSYNC_POL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_PIXELS);
  localparam logic [HW-1:0] H_SYN0 = HW'(H_PIXELS + H_FRONT_PORCH);
  localparam logic [HW-1:0] H_SYN1 = HW'(H_PIXELS + H_FRONT_PORCH + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_MSK  = HW'(SCALE - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_PIXELS);
  localparam logic [VW-1:0] V_SYN0 = VW'(V_PIXELS + V_FRONT_PORCH);
  localparam logic [VW-1:0] V_SYN1 = VW'(V_PIXELS + V_FRONT_PORCH + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_MSK  = VW'(SCALE - 1);

  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_idx;
  logic              r_page;
  logic              r_mode;

  logic              w_h_last, w_v_last, w_act;
  logic              w_sx_step, w_sy_step;
  logic              w_hs, w_vs, w_vb, w_fs;
  logic [IDX_W-1:0]  w_row_nx;
  logic [ADDR_W-1:0] w_word;
  logic [BK_W-1:0]   w_bank;

  assign w_h_last  = r_h == H_LAST;
  assign w_v_last  = r_v == V_LAST;
  assign w_act     = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_sx_step = ((r_h + 1'b1) & H_MSK) == '0;
  assign w_sy_step = ((r_v + 1'b1) & V_MSK) == '0;
  assign w_hs = (r_h >= H_SYN0 && r_h < H_SYN1) ? HS_ON : !HS_ON;
  assign w_vs = (r_v >= V_SYN0 && r_v < V_SYN1) ? VS_ON : !VS_ON;
  assign w_vb = r_v >= V_ACT;
  assign w_fs = (r_h == '0) && (r_v == '0);
  assign w_bank = BK_W'(r_idx & IDX_W'(NUM_BANKS - 1));
  assign w_word = ADDR_W'(AF_W'(r_idx >> BK_SH)
                  + (r_page ? AF_W'(PAGE_WORDS) : AF_W'(0)));

  // row base steps by one source row every SCALE lines, only inside the picture
  always_comb begin
    w_row_nx = r_row;
    if (w_v_last)
      w_row_nx = '0;
    else if (r_v < V_ACT && w_sy_step)
      w_row_nx = r_row + IDX_W'(SRC_W);
  end

  // mode has no reset value of its own: the frame after reset uses the input level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h    <= '0;
      r_v    <= '0;
      r_row  <= '0;
      r_idx  <= '0;
      r_page <= 1'b0;
      r_mode <= mode;
    end else if (w_h_last) begin
      r_h   <= '0;
      r_v   <= w_v_last ? '0 : r_v + 1'b1;
      r_row <= w_row_nx;
      r_idx <= w_row_nx;
      if (w_v_last) begin
        r_page <= page_sel;
        r_mode <= mode;
      end
    end else begin
      r_h <= r_h + 1'b1;
      if (w_act && w_sx_step)
        r_idx <= r_idx + 1'b1;
    end
  end

  logic [BK_W-1:0] r_s1_bank, r_s2_bank;
  logic r_s1_act, r_s1_hs, r_s1_vs, r_s1_vb, r_s1_fs, r_s1_mode, r_s1_page;
  logic r_s2_act, r_s2_hs, r_s2_vs, r_s2_vb, r_s2_fs, r_s2_mode, r_s2_page;
  logic [7:0] w_q, w_r, w_g, w_b;

  assign w_q = bank_q[{r_s2_bank, 3'b000} +: 8];

  always_comb begin
    w_r = w_q;
    w_g = w_q;
    w_b = w_q;
    if (!r_s2_mode) begin
      w_r = {w_q[7:5], w_q[7:5], w_q[7:6]};
      w_g = {w_q[4:2], w_q[4:2], w_q[4:3]};
      w_b = {4{w_q[1:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_addr   <= '0;
      r_s1_bank   <= '0;
      r_s1_act    <= 1'b0;
      r_s1_hs     <= !HS_ON;
      r_s1_vs     <= !VS_ON;
      r_s1_vb     <= 1'b0;
      r_s1_fs     <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_page   <= 1'b0;
      r_s2_bank   <= '0;
      r_s2_act    <= 1'b0;
      r_s2_hs     <= !HS_ON;
      r_s2_vs     <= !VS_ON;
      r_s2_vb     <= 1'b0;
      r_s2_fs     <= 1'b0;
      r_s2_mode   <= 1'b0;
      r_s2_page   <= 1'b0;
      page_active <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= !HS_ON;
      vsync       <= !VS_ON;
      draw_area   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      if (w_act)
        bank_addr <= {NUM_BANKS{w_word}};
      r_s1_bank   <= w_bank;
      r_s1_act    <= w_act;
      r_s1_hs     <= w_hs;
      r_s1_vs     <= w_vs;
      r_s1_vb     <= w_vb;
      r_s1_fs     <= w_fs;
      r_s1_mode   <= r_mode;
      r_s1_page   <= r_page;
      r_s2_bank   <= r_s1_bank;
      r_s2_act    <= r_s1_act;
      r_s2_hs     <= r_s1_hs;
      r_s2_vs     <= r_s1_vs;
      r_s2_vb     <= r_s1_vb;
      r_s2_fs     <= r_s1_fs;
      r_s2_mode   <= r_s1_mode;
      r_s2_page   <= r_s1_page;
      page_active <= r_s2_page;
      frame_start <= r_s2_fs;
      vblank      <= r_s2_vb;
      hsync       <= r_s2_hs;
      vsync       <= r_s2_vs;
      draw_area   <= r_s2_act;
      red         <= r_s2_act ? w_r : 8'h00;
      green       <= r_s2_act ? w_g : 8'h00;
      blue        <= r_s2_act ? w_b : 8'h00;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout: default timing, a small-timing copy
// for whole-frame behaviour, and a SCALE=2 copy for address replication.
module tb_video_scanout;

  logic clk = 1'b0;
  logic rst_n;
  logic page_sel;
  logic mode;
  logic fa_en, fb_en;
  logic [7:0] fa_val, fb_val;

  logic [19:0] a_addr, b_addr, c_addr;
  logic [15:0] a_q, b_q, c_q;
  logic a_pg, a_fs, a_vb, a_hs, a_vs, a_da;
  logic b_pg, b_fs, b_vb, b_hs, b_vs, b_da;
  logic c_pg, c_fs, c_vb, c_hs, c_vs, c_da;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

  int n_cmp = 0;
  int n_err = 0;
  int n = 0;

  always #5 clk = ~clk;

  video_scanout u_a (
    .clk(clk), .rst_n(rst_n), .page_sel(page_sel), .mode(mode),
    .bank_addr(a_addr), .bank_q(a_q), .page_active(a_pg),
    .frame_start(a_fs), .vblank(a_vb), .hsync(a_hs), .vsync(a_vs),
    .draw_area(a_da), .red(a_r), .green(a_g), .blue(a_b)
  );

  video_scanout #(
    .H_PIXELS(16), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(3),
    .V_PIXELS(8), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .page_sel(page_sel), .mode(mode),
    .bank_addr(b_addr), .bank_q(b_q), .page_active(b_pg),
    .frame_start(b_fs), .vblank(b_vb), .hsync(b_hs), .vsync(b_vs),
    .draw_area(b_da), .red(b_r), .green(b_g), .blue(b_b)
  );

  video_scanout #(.SCALE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .page_sel(page_sel), .mode(mode),
    .bank_addr(c_addr), .bank_q(c_q), .page_active(c_pg),
    .frame_start(c_fs), .vblank(c_vb), .hsync(c_hs), .vsync(c_vs),
    .draw_area(c_da), .red(c_r), .green(c_g), .blue(c_b)
  );

  // VRAM model: each bank returns {bank, addr[6:0]} one clock after the address
  always @(posedge clk) begin
    a_q <= fa_en ? {fa_val, fa_val} : {1'b1, a_addr[16:10], 1'b0, a_addr[6:0]};
    b_q <= fb_en ? {fb_val, fb_val} : {1'b1, b_addr[16:10], 1'b0, b_addr[6:0]};
    c_q <= {1'b1, c_addr[16:10], 1'b0, c_addr[6:0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic goto(input int t);
    while (n < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string p);
    chk({p, "_hs"}, 32'(a_hs), 32'd0);
    chk({p, "_vs"}, 32'(a_vs), 32'd1);
    chk({p, "_da"}, 32'(a_da), 32'd0);
    chk({p, "_vb"}, 32'(a_vb), 32'd0);
    chk({p, "_fs"}, 32'(a_fs), 32'd0);
    chk({p, "_pg"}, 32'(a_pg), 32'd0);
    chk({p, "_rgb"}, {8'h0, a_r, a_g, a_b}, 32'd0);
    chk({p, "_addr"}, 32'(a_addr), 32'd0);
    chk({p, "_bpg"}, 32'(b_pg), 32'd0);
  endtask

  initial begin : main
    int r1, r2, hi, dr;
    int f1, f2, lo, bd, bv, s1, s2;
    int fr0, fr1;
    logic pv;

    rst_n = 1'b0; page_sel = 1'b0; mode = 1'b1;
    fa_en = 1'b0; fb_en = 1'b0; fa_val = 8'h00; fb_val = 8'h00;
    repeat (3) step();
    idle_chk("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;

    goto(1); chk("fs_n1", 32'(a_fs), 32'd0);
    goto(2); chk("fs_n2", 32'(a_fs), 32'd0);
    goto(3);
    chk("fs_n3", 32'(a_fs), 32'd1);
    chk("da_n3", 32'(a_da), 32'd1);
    chk("px0", 32'(a_r), 32'h00);
    chk("b_fs_n3", 32'(b_fs), 32'd1);
    chk("c_fs_n3", 32'(c_fs), 32'd1);
    goto(4);
    chk("fs_n4", 32'(a_fs), 32'd0);
    chk("px1", 32'(a_r), 32'h80);
    goto(6); chk("addr_h5", 32'(a_addr), 32'h00802);
    goto(7); chk("px4", 32'(a_r), 32'h02);
    goto(8);
    chk("px5", {8'h0, a_r, a_g, a_b}, 32'h828282);
    fa_val = 8'h5A; fa_en = 1'b1;
    goto(12); chk("grey5a", {8'h0, a_r, a_g, a_b}, 32'h5A5A5A);

    r1 = -1; r2 = -1; hi = 0; dr = 0;
    pv = a_hs;
    for (int k = 0; k < 2500 && r2 < 0; k++) begin
      step();
      if (!pv && a_hs) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
      end
      if (r1 >= 0 && r2 < 0) begin
        hi += int'(a_hs);
        dr += int'(a_da);
      end
      pv = a_hs;
    end
    chk("hs_period", 32'(r2 - r1), 32'd960);
    chk("hs_active", 32'(hi), 32'd32);
    chk("da_per_line", 32'(dr), 32'd800);

    goto(1863);
    chk("hblank_da", 32'(a_da), 32'd0);
    chk("hblank_rgb", {8'h0, a_r, a_g, a_b}, 32'd0);
    fa_en = 1'b0;

    f1 = -1; f2 = -1; lo = 0; bd = 0; bv = 0; s1 = -1; s2 = -1;
    pv = b_vs;
    for (int k = 0; k < 1200 && (f2 < 0 || s2 < 0); k++) begin
      step();
      if (pv && !b_vs) begin
        if (f1 < 0) f1 = n;
        else if (f2 < 0) f2 = n;
      end
      if (f1 >= 0 && f2 < 0) begin
        lo += int'(!b_vs);
        bd += int'(b_da);
        bv += int'(b_vb);
      end
      if (b_fs) begin
        if (s1 < 0) s1 = n;
        else if (s2 < 0) s2 = n;
      end
      pv = b_vs;
    end
    chk("vs_period", 32'(f2 - f1), 32'd288);
    chk("vs_active", 32'(lo), 32'd48);
    chk("da_per_frame", 32'(bd), 32'd128);
    chk("vb_per_frame", 32'(bv), 32'd96);
    chk("fs_period", 32'(s2 - s1), 32'd288);

    fr0 = (n / 288 + 1) * 288;
    fr1 = fr0 + 288;
    goto(fr0 + 98);
    page_sel = 1'b1;
    mode = 1'b0;
    goto(fr0 + 123);
    chk("pg_midframe", 32'(b_pg), 32'd0);
    chk("mode_midframe", {8'h0, b_r, b_g, b_b}, 32'h282828);
    goto(fr1);     chk("addr_hold", 32'(b_addr), 32'h0FC3F);
    goto(fr1 + 1); chk("addr_page1", 32'(b_addr), 32'h10040);
    goto(fr1 + 2);
    chk("pg_before_fs", 32'(b_pg), 32'd0);
    chk("fs_before", 32'(b_fs), 32'd0);
    goto(fr1 + 3);
    chk("pg_at_fs", 32'(b_pg), 32'd1);
    chk("fs_at", 32'(b_fs), 32'd1);
    chk("rgb332_40", {8'h0, b_r, b_g, b_b}, 32'h490000);
    goto(fr1 + 24);
    fb_val = 8'hE3; fb_en = 1'b1;
    goto(fr1 + 32); chk("rgb332_e3", {8'h0, b_r, b_g, b_b}, 32'hFF00FF);
    goto(fr1 + 47);
    chk("b_hblank_da", 32'(b_da), 32'd0);
    chk("b_hblank_rgb", {8'h0, b_r, b_g, b_b}, 32'd0);
    fb_en = 1'b0;

    page_sel = 1'b0;
    mode = 1'b1;
    rst_n = 1'b0;
    step();
    idle_chk("rst1");
    step();
    rst_n = 1'b1;
    n = 0;

    goto(2); chk("rfs_n2", 32'(a_fs), 32'd0);
    goto(3);
    chk("rfs_n3", 32'(a_fs), 32'd1);
    chk("c_px00", 32'(c_r), 32'h00);
    goto(5); chk("c_px20", {8'h0, c_r, c_g, c_b}, 32'h808080);
    goto(7); chk("c_px40", 32'(c_r), 32'h01);
    goto(850); chk("rhs_850", 32'(a_hs), 32'd0);
    goto(851); chk("rhs_851", 32'(a_hs), 32'd1);
    goto(882); chk("rhs_882", 32'(a_hs), 32'd1);
    goto(883); chk("rhs_883", 32'(a_hs), 32'd0);
    goto(960); chk("c_addr_hold", 32'(c_addr), 32'h31CC7);
    goto(961); chk("c_addr_01", 32'(c_addr), 32'h00000);
    goto(963); chk("c_px01", 32'(c_r), 32'h00);
    goto(964); chk("c_px11", 32'(c_r), 32'h00);
    goto(965); chk("c_px21", 32'(c_r), 32'h80);
    goto(1810); chk("rhs_1810", 32'(a_hs), 32'd0);
    goto(1811); chk("rhs_1811", 32'(a_hs), 32'd1);
    goto(1921); chk("c_addr_row2", 32'(c_addr), 32'h320C8);
    goto(1923); chk("c_px02", 32'(c_r), 32'h48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
